// File: rtl/uart_pkg.sv
// Shared UART package: byte width and byte type used by the rx/tx blocks and the rx FIFO.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART rx FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the FIFO pointers.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  uart_byte_t mem_q [DEPTH];

  // Write port: a byte lands in its slot on the edge of an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver; it never stalls the receiver and drops on full.
// Optional feature: define UART_RX_FIFO_LEVEL_EN to add the out_level occupancy output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   uart_clk,
  input  logic                   uart_rst_n,
  input  logic [UART_DATA_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   full,
  output logic                   overflow,
`ifdef UART_RX_FIFO_LEVEL_EN
  output logic [$clog2(DEPTH):0] out_level,
`endif
  input  logic                   overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   overflow_q, overflow_d;
  logic                   empty_s, full_s;
  logic                   push_s, pop_s, wr_en_s, drop_s;
  logic [UART_DATA_W-1:0] rd_data_s;

  // Pointer, flag and handshake decode from registered state plus this cycle's requests.
  always_comb begin
    empty_s    = (wr_ptr_q == rd_ptr_q);
    full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_s     = in_valid && in_ready_q;
    pop_s      = !empty_s && out_ready;
    // At full a same-cycle pop frees the slot being overwritten, so the push is kept.
    wr_en_s    = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in_ready_d = 1'b1;
    overflow_d = overflow_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A drop outranks a clear in the same cycle so no loss goes unreported.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; the storage array itself is left unreset.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (uart_clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data_s)
  );

  // Head byte is masked while empty so stale storage never leaks out after reset.
  always_comb begin
    if (empty_s) begin
      out_data = '0;
    end else begin
      out_data = rd_data_s;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = !empty_s;
  assign full      = full_s;
  assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_LEVEL_EN
  assign out_level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at DEPTH=16; outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       overflow;
  logic       overflow_clr;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [4:0] out_level;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_b;

  uart_rx_fifo #(
    .DEPTH (16)
  ) dut (
    .uart_clk     (clk),
    .uart_rst_n   (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .full         (full),
    .overflow     (overflow),
`ifdef UART_RX_FIFO_LEVEL_EN
    .out_level    (out_level),
`endif
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef UART_RX_FIFO_LEVEL_EN
    check(tag, 32'(out_level), 32'(exp));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(base + 8'(i));
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [7:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(out_data), 32'(8'(base + 8'(i))));
      cyc();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check_level("rst_level", 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("in_ready_up", 32'(in_ready), 32'd1);

    // Single push into empty FIFO, held while out_ready=0
    in_data  = 8'hA5;
    in_valid = 1'b1;
    check("pre_push_empty", 32'(out_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    check("a5_valid", 32'(out_valid), 32'd1);
    check("a5_data", 32'(out_data), 32'hA5);
    check_level("a5_level", 1);
    cyc();
    cyc();
    check("a5_hold_valid", 32'(out_valid), 32'd1);
    check("a5_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("a5_popped", 32'(out_valid), 32'd0);
    // out_ready while empty has no effect
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("empty_pop_ignored", 32'(out_valid), 32'd0);
    check_level("empty_pop_level", 0);

    // Fill to full, then a dropped push
    fill(8'h00);
    check("fill_full", 32'(full), 32'd1);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    check_level("fill_level", 16);
    in_data  = 8'h55;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("drop_full", 32'(full), 32'd1);
    check("drop_ovf", 32'(overflow), 32'd1);
    check_level("drop_level", 16);
    drain("drain_0x", 8'h00, 16);
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_not_full", 32'(full), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Simultaneous push and pop at full
    fill(8'h10);
    check("full2", 32'(full), 32'd1);
    in_data   = 8'h77;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("sim_head_before", 32'(out_data), 32'h10);
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("sim_full", 32'(full), 32'd1);
    check("sim_no_ovf", 32'(overflow), 32'd0);
    check("sim_head_after", 32'(out_data), 32'h11);
    check_level("sim_level", 16);
    drain("sim_drain", 8'h11, 15);
    check("sim_last_data", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("sim_empty", 32'(out_valid), 32'd0);
    check("sim_ovf_end", 32'(overflow), 32'd0);

    // overflow_clr coinciding with a drop loses to the drop
    fill(8'h20);
    in_data  = 8'h99;
    in_valid = 1'b1;
    cyc();
    check("ovf_set", 32'(overflow), 32'd1);
    in_data      = 8'h9A;
    overflow_clr = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("clr_vs_drop", 32'(overflow), 32'd1);
    cyc();
    overflow_clr = 1'b0;
    check("clr_alone", 32'(overflow), 32'd0);
    check_level("clr_level", 16);
    drain("clr_drain", 8'h20, 16);
    check("clr_empty", 32'(out_valid), 32'd0);

    // 40 pushes interleaved with pops, pointers wrap
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(i * 7 + 3);
      out_ready = (i % 3 != 0);
      check("mix_valid", 32'(out_valid), 32'(model_q.size() != 0));
      if (out_ready && model_q.size() != 0) begin
        exp_b = model_q.pop_front();
        check("mix_data", 32'(out_data), 32'(exp_b));
      end
      model_q.push_back(in_data);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_level("mix_level", 14);
    for (int k = 0; k < 20 && model_q.size() != 0; k++) begin
      exp_b = model_q.pop_front();
      check("mix_drain", 32'(out_data), 32'(exp_b));
      cyc();
    end
    out_ready = 1'b0;
    check("mix_model_empty", 32'(model_q.size()), 32'd0);
    check("mix_empty", 32'(out_valid), 32'd0);
    check("mix_no_ovf", 32'(overflow), 32'd0);

    // Reset with 5 bytes buffered
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hE0 + 8'(i));
      cyc();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check_level("pre_rst_level", 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_data", 32'(out_data), 32'h00);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_empty", 32'(out_valid), 32'd0);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_first", 32'(out_data), 32'h3C);
    check_level("postrst_level", 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("postrst_drained", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
